// File: rtl/hazard_ctrl.sv
// hazard_ctrl: IF/ID register with RAW stall and taken-branch flush control; HAZARD_FORWARDING_EN limits stalls to load-use
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        branch_taken,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        issue_valid,
  output logic        stall
);
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2, ex_rd, mem_rd;
  logic is_ld, is_st, is_br, is_imm, is_op, use1, use2, wr;
  logic ex_wr, mem_wr, hit_ex, hit_mem, hazard;
`ifdef HAZARD_FORWARDING_EN
  logic ex_ld;
`endif
  always_comb begin
    op = id_instr[6:0];
    rd = id_instr[11:7];
    rs1 = id_instr[19:15];
    rs2 = id_instr[24:20];
    is_ld = op == 7'b0000011;
    is_st = op == 7'b0100011;
    is_br = op == 7'b1100011;
    is_imm = op == 7'b0010011;
    is_op = op == 7'b0110011;
    use1 = is_ld || is_st || is_br || is_imm || is_op;
    use2 = is_st || is_br || is_op;
    wr = (is_ld || is_imm || is_op) && rd != 5'd0;
    hit_ex = ex_wr && ex_rd != 5'd0 && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
    hit_mem = mem_wr && mem_rd != 5'd0 && ((use1 && rs1 == mem_rd) || (use2 && rs2 == mem_rd));
`ifdef HAZARD_FORWARDING_EN
    hazard = hit_ex && ex_ld;
`else
    hazard = hit_ex || hit_mem;
`endif
    stall = id_valid && hazard;
    if_ready = !stall || branch_taken;
    issue_valid = id_valid && !stall && !branch_taken;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= 32'd0;
      id_pc <= 32'd0;
      ex_rd <= 5'd0;
      ex_wr <= 1'b0;
      mem_rd <= 5'd0;
      mem_wr <= 1'b0;
`ifdef HAZARD_FORWARDING_EN
      ex_ld <= 1'b0;
`endif
    end else begin
      id_valid <= branch_taken ? 1'b0 : stall ? id_valid : if_valid;
      id_instr <= (branch_taken || stall) ? id_instr : if_instr;
      id_pc <= (branch_taken || stall) ? id_pc : if_pc;
      ex_rd <= rd;
      ex_wr <= issue_valid && wr;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
`ifdef HAZARD_FORWARDING_EN
      ex_ld <= issue_valid && is_ld;
`endif
    end
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 if_valid  in  1  fetch stage presents an instruction.
REQ-005 if_instr  in  32  fetched instruction.
REQ-006 if_pc  in  32  PC of the fetched instruction.
REQ-007 branch_taken  in  1  taken branch resolved in EX this cycle.
REQ-008 if_ready  out  1  fetch may advance (instruction accepted into IF/ID).
REQ-009 id_valid  out  1  IF/ID register holds a live instruction.
REQ-010 id_instr  out  32  IF/ID instruction (feeds decode and immediate generation).
REQ-011 id_pc  out  32  IF/ID PC.
REQ-012 issue_valid  out  1  ID instruction advances into EX this cycle.
REQ-013 stall  out  1  RAW hazard holds the ID stage this cycle.

Function
REQ-014 Decode of id_instr SHALL be: rd=[11:7], rs1=[19:15], rs2=[24:20], class from opcode [6:0].
- load 0000011, store 0100011, branch 1100011, op-imm 0010011, op 0110011.
REQ-015 Source-register use SHALL be defined per class.
- uses_rs1: load, store, branch, op-imm, op.
- uses_rs2: store, branch, op.
REQ-016 writes_rd SHALL be asserted for load, op-imm and op only, and only when rd != 0.
REQ-017 Any other opcode SHALL be treated as a NOP: no sources, no write, always issuable.
REQ-018 A source SHALL match a tracked slot only if the slot is a writer, the source is used, the register numbers are equal, and the register is nonzero.
REQ-019 Two tracking slots (EX, MEM) SHALL each hold rd, wr and is_load, and SHALL advance every cycle.
- MEM <= EX.
- EX <= decoded ID fields when issue_valid, otherwise a bubble (wr=0, is_load=0).
REQ-020 stall (combinational) SHALL be asserted only when id_valid=1 and the hazard condition of REQ-035/036 is met.
REQ-021 Taken-branch behaviour: when branch_taken=1:
- next cycle id_valid=0;
- issue_valid=0 this cycle (ID instruction squashed);
- if_ready=1;
- branch_taken takes priority over stall.
REQ-022 if_ready SHALL equal (!stall || branch_taken).
REQ-023 issue_valid SHALL equal (id_valid && !stall && !branch_taken).
REQ-024 IF/ID update priority SHALL be: branch_taken -> id_valid<=0; else stall -> hold all IF/ID fields; else load if_valid/if_instr/if_pc.
REQ-025 When id_valid=0, the block SHALL NOT stall, issue or write a tracking slot.
REQ-026 A stall SHALL last until the hazarding writer leaves the window; the hazard SHALL re-evaluate every cycle with no latching.
REQ-027 Write-back to ID hazards are resolved by register-file bypass; the block SHALL NOT track WB.
REQ-028 IF/ID to EX latency SHALL be exactly 1 cycle when no stall or flush occurs.

Reset
REQ-029 On rst assertion, the block SHALL asynchronously clear: id_valid=0, id_instr=0, id_pc=0, both tracking slots to bubble.
REQ-030 While rst=1, the outputs SHALL be: stall=0, issue_valid=0, if_ready=1.
REQ-031 Reset asserted mid-stall SHALL drop the pending instruction; the first post-reset edge loads from fetch.

Configuration
REQ-032 The macro HAZARD_FORWARDING_EN SHALL select the hazard condition.
REQ-033 With HAZARD_FORWARDING_EN defined, the datapath forwards from EX/MEM and MEM/WB.
REQ-034 Without HAZARD_FORWARDING_EN, the datapath has no forwarding.
REQ-035 With HAZARD_FORWARDING_EN: stall SHALL be asserted only for the EX slot with is_load=1 matching rs1 or rs2 (load-use; one bubble).
REQ-036 Without HAZARD_FORWARDING_EN: stall SHALL be asserted on any match against the EX or MEM slot (up to two bubbles).

Verification
REQ-037 With forwarding: lw x5,0(x1) (0x0000A283), then add x6,x5,x7 (0x00728333) -> one cycle stall=1, if_ready=0, issue_valid=0; add issues the next cycle.
REQ-038 Without forwarding: addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333) -> stall=1 for two cycles; add issues on the third cycle.
REQ-039 addi x0,x0,1 (0x00100013), then add x6,x0,x0 (0x00000333) -> no stall in either configuration.
REQ-040 Load-use stall active and branch_taken=1 in the same cycle -> issue_valid=0, if_ready=1; id_valid=0 next cycle; EX slot holds a bubble.
REQ-041 rst pulsed during a stall -> id_valid=0, stall=0 immediately; the next if_valid instruction issues one cycle after capture.
REQ-042 Unknown opcode 0x0000007F, then add x6,x5,x5 -> both issue back-to-back with no stall.
